// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: shared types and constants for the button debouncer.
//   state_t             - per-channel debounce FSM states
//   DEBOUNCE_CYCLES_DEF - default stable-cycle count (20 ms at 50 MHz)
//   LONG_CYCLES_DEF     - default long-press hold count (1 s at 50 MHz)
//   cnt_width(n)        - bits needed to hold the value n
package btn_debounce_pkg;

  typedef enum logic {
    ST_STABLE,
    ST_CHECK
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int LONG_CYCLES_DEF     = 50000000;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// btn_debounce_chan: one push-button channel.
//   Two-flop synchronizer, optional inversion, STABLE/CHECK debounce FSM,
//   registered press/release strobes and an optional long-press detector
//   (compiled in when BTN_DEBOUNCE_LONGPRESS_EN is defined).
// Ports:
//   i_clk      - system clock
//   i_reset    - synchronous, active-high reset
//   i_raw      - asynchronous raw button pin
//   o_level    - debounced level, 1 = pressed
//   o_press    - one-cycle strobe on an accepted 0->1 change
//   o_release  - one-cycle strobe on an accepted 1->0 change
//   o_long     - one-cycle strobe after a long hold (0 when feature disabled)
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int INVERT          = 1,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int             CW         = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  C_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           C_IDLE_RAW = (INVERT != 0) ? 1'b1 : 1'b0;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_sample;
  logic          w_diff;
  state_t        r_state;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          r_release;

  // Reset loads the idle pin level so leaving reset never looks like a press.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= C_IDLE_RAW;
      r_sync2 <= C_IDLE_RAW;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = (INVERT != 0) ? ~r_sync2 : r_sync2;
  assign w_diff   = (w_sample != r_level);

  // r_cnt counts differing samples already registered; the flip happens on
  // the edge that registers the DEBOUNCE_CYCLES-th one, hence C_LAST.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_STABLE;
      r_level   <= 1'b0;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          r_cnt <= '0;
          if (w_diff) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_level   <= w_sample;
              r_press   <= w_sample;
              r_release <= ~w_sample;
            end else begin
              r_state <= ST_CHECK;
              r_cnt   <= CW'(1);
            end
          end
        end
        ST_CHECK: begin
          if (!w_diff) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_level   <= w_sample;
            r_press   <= w_sample;
            r_release <= ~w_sample;
            r_state   <= ST_STABLE;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam int            HW     = cnt_width(LONG_CYCLES);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] r_hold;
  logic          r_long;

  // Saturating at H_MAX gives one strobe per press; release clears r_hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_level) begin
        r_hold <= '0;
      end else if (r_hold != H_MAX) begin
        r_hold <= r_hold + HW'(1);
        r_long <= (r_hold == H_LAST);
      end
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: multi-channel push-button conditioner feeding a button PIO.
//   Each channel is synchronized, optionally inverted (active-low pins) and
//   debounced independently. Optional long-press strobes are enabled by
//   defining BTN_DEBOUNCE_LONGPRESS_EN; otherwise long_press is tied low.
// Ports:
//   clk           - system clock
//   reset         - synchronous, active-high reset
//   btn_raw       - asynchronous raw button pins
//   btn_out       - debounced levels, 1 = pressed (PIO in_port)
//   press_pulse   - one-cycle strobe per accepted press
//   release_pulse - one-cycle strobe per accepted release
//   long_press    - one-cycle strobe per long hold
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int INVERT          = 1,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_chan (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_raw     (btn_raw[g]),
      .o_level   (btn_out[g]),
      .o_press   (press_pulse[g]),
      .o_release (release_pulse[g]),
      .o_long    (long_press[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

  localparam int DEB    = 8;
  localparam int LONGC  = 32;
  localparam bit INVERT = 1'b1;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_out, press_pulse, release_pulse, long_press;

  btn_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEB),
    .INVERT          (1),
    .LONG_CYCLES     (LONGC)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .btn_out       (btn_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 2-sample pipeline delay, then a run-length count of
  // consecutive samples that disagree with the accepted level.
  logic [3:0] m_d1, m_d2, m_lvl, m_press, m_rel, m_long;
  int         m_run  [4];
  int         m_hold [4];

  task automatic model_step(input logic [3:0] raw, input logic rst);
    logic [3:0] act;
    logic       old_lvl;
    act = INVERT ? ~raw : raw;
    for (int c = 0; c < 4; c++) begin
      if (rst) begin
        m_d1[c] = 1'b0; m_d2[c] = 1'b0; m_lvl[c] = 1'b0;
        m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0;
        m_run[c] = 0; m_hold[c] = 0;
      end else begin
        old_lvl = m_lvl[c];
        m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0;
        if (m_d2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_lvl[c]   = m_d2[c];
            m_press[c] = m_d2[c];
            m_rel[c]   = ~m_d2[c];
            m_run[c]   = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        if (LONG_EN) begin
          if (old_lvl) begin
            if (m_hold[c] < LONGC) begin
              m_hold[c]++;
              if (m_hold[c] == LONGC) m_long[c] = 1'b1;
            end
          end else begin
            m_hold[c] = 0;
          end
        end
        m_d2[c] = m_d1[c];
        m_d1[c] = act[c];
      end
    end
  endtask

  // Per-scenario bookkeeping of observed strobes (edge index k from 1).
  int k;
  int first_press [4];
  int first_rel   [4];
  int first_long  [4];
  int cnt_press   [4];
  int cnt_rel     [4];
  int cnt_long    [4];

  task automatic scen_start();
    k = 0;
    for (int c = 0; c < 4; c++) begin
      first_press[c] = 0; first_rel[c] = 0; first_long[c] = 0;
      cnt_press[c] = 0; cnt_rel[c] = 0; cnt_long[c] = 0;
    end
  endtask

  task automatic cyc(input logic [3:0] raw, input logic rst);
    @(negedge clk);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    model_step(raw, rst);
    #1;
    check("btn_out",       {28'd0, btn_out},       {28'd0, m_lvl});
    check("press_pulse",   {28'd0, press_pulse},   {28'd0, m_press});
    check("release_pulse", {28'd0, release_pulse}, {28'd0, m_rel});
    check("long_press",    {28'd0, long_press},    {28'd0, m_long});
    k++;
    for (int c = 0; c < 4; c++) begin
      if (press_pulse[c]) begin
        cnt_press[c]++;
        if (first_press[c] == 0) first_press[c] = k;
      end
      if (release_pulse[c]) begin
        cnt_rel[c]++;
        if (first_rel[c] == 0) first_rel[c] = k;
      end
      if (long_press[c]) begin
        cnt_long[c]++;
        if (first_long[c] == 0) first_long[c] = k;
      end
    end
  endtask

  logic [3:0] r;

  initial begin
    btn_raw = 4'hF;
    reset   = 1'b1;
    r       = 4'hF;

    // Reset with all pins idle, then 20 quiet cycles.
    scen_start();
    repeat (3) cyc(r, 1'b1);
    scen_start();
    repeat (20) cyc(r, 1'b0);
    check("idle_pulses",
          cnt_press[0] + cnt_press[1] + cnt_press[2] + cnt_press[3] +
          cnt_rel[0] + cnt_rel[1] + cnt_rel[2] + cnt_rel[3] +
          cnt_long[0] + cnt_long[1] + cnt_long[2] + cnt_long[3], 0);

    // Channel 0 press: accepted on the 10th edge.
    r[0] = 1'b0;
    scen_start();
    repeat (12) cyc(r, 1'b0);
    check("ch0_press_edge", first_press[0], 10);
    check("ch0_press_cnt",  cnt_press[0], 1);
    check("ch0_others",     cnt_press[1] + cnt_press[2] + cnt_press[3], 0);

    // Channel 1 glitch shorter than the debounce window.
    scen_start();
    r[1] = 1'b0;
    repeat (5) cyc(r, 1'b0);
    r[1] = 1'b1;
    repeat (20) cyc(r, 1'b0);
    check("ch1_glitch", cnt_press[1] + cnt_rel[1], 0);

    // Channel 2 bounce every 3 cycles, then settles pressed.
    scen_start();
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) r[2] = ~r[2];
      cyc(r, 1'b0);
    end
    check("ch2_bounce", cnt_press[2] + cnt_rel[2], 0);
    r[2] = 1'b0;
    scen_start();
    repeat (15) cyc(r, 1'b0);
    check("ch2_press_edge", first_press[2], 10);
    check("ch2_press_cnt",  cnt_press[2], 1);

    // Channel 0 release.
    r[0] = 1'b1;
    scen_start();
    repeat (15) cyc(r, 1'b0);
    check("ch0_rel_edge",  first_rel[0], 10);
    check("ch0_rel_cnt",   cnt_rel[0], 1);
    check("ch0_rel_nopr",  cnt_press[0], 0);

    // Channel 0 long hold.
    r[0] = 1'b0;
    scen_start();
    repeat (69) cyc(r, 1'b0);
    check("ch0_lp_press", first_press[0], 10);
    check("ch0_lp_cnt",   cnt_long[0], LONG_EN ? 1 : 0);
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    check("ch0_lp_dist",  first_long[0] - first_press[0], LONGC);
`endif

    // Reset in the middle of a channel 3 count, button kept held.
    r[3] = 1'b0;
    scen_start();
    repeat (7) cyc(r, 1'b0);
    check("ch3_precount", {31'd0, btn_out[3]}, 0);
    repeat (2) cyc(r, 1'b1);
    check("rst_out",   {28'd0, btn_out}, 0);
    check("rst_pulse", {24'd0, press_pulse, release_pulse}, 0);
    scen_start();
    repeat (15) cyc(r, 1'b0);
    check("ch3_reaccept_edge", first_press[3], 10);
    check("ch0_reaccept_edge", first_press[0], 10);

    // Randomized phase: alternating quiet and bouncy stretches, rare resets.
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 200; i++) begin
        for (int c = 0; c < 4; c++) begin
          if ((blk % 2 == 0) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 3) == 0))
            r[c] = ~r[c];
        end
        cyc(r, ($urandom_range(0, 399) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
